// File: rtl/secuencia_pkg.sv
// Shared types and defaults for the run-length Moore detector.
// State Sk means the last k sampled inputs were 1.
package secuencia_pkg;

    localparam int unsigned RUN_LEN_DEFAULT = 2;
    localparam int unsigned RUN_LEN_MAX     = 15;

    typedef enum logic [3:0] {
        S0,  S1,  S2,  S3,  S4,  S5,  S6,  S7,
        S8,  S9,  S10, S11, S12, S13, S14, S15
    } state_t;

endpackage

// File: rtl/secuencia_moore.sv
// Moore detector: z is high once RUN_LEN consecutive w=1 samples have been seen,
// and stays high while w remains 1.
module secuencia_moore
    import secuencia_pkg::*;
#(
    parameter int unsigned RUN_LEN = RUN_LEN_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic w,
    output logic z
);

    localparam state_t S_RUN = state_t'(RUN_LEN[3:0]);

    if (RUN_LEN < 1 || RUN_LEN > RUN_LEN_MAX) begin : g_bad_len
        $error("secuencia_moore: RUN_LEN must be in 1..15");
    end

    state_t state;
    state_t state_nx;

    // Next-state logic; encodings above S_RUN are unreachable and fall back to S0.
    always_comb begin
        state_nx = S0;
        if (state > S_RUN) begin
            state_nx = S0;
        end else if (w) begin
            state_nx = (state == S_RUN) ? S_RUN : state_t'(state + 4'd1);
        end
    end

    // State register; z is registered alongside it from the state being entered,
    // so it equals a decode of the current state with no path from w.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S0;
            z     <= 1'b0;
        end else begin
            state <= state_nx;
            z     <= (state_nx == S_RUN);
        end
    end

endmodule

// File: tb/tb_secuencia_moore.sv
// Randomized and directed bench for secuencia_moore at RUN_LEN = 1, 2 and 3,
// against a saturating run-count model.
module tb_secuencia_moore;
    import secuencia_pkg::*;

    logic clk;
    logic reset;
    logic w;
    logic z1, z2, z3;
    logic [2:0] zv;

    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned run [3];
    int unsigned len [3];

    assign zv = {z3, z2, z1};

    secuencia_moore #(.RUN_LEN(1)) u_len1 (.clk(clk), .reset(reset), .w(w), .z(z1));
    secuencia_moore #(.RUN_LEN(2)) u_len2 (.clk(clk), .reset(reset), .w(w), .z(z2));
    secuencia_moore #(.RUN_LEN(3)) u_len3 (.clk(clk), .reset(reset), .w(w), .z(z3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive w, take one rising edge, update the model.
    task automatic clock_in(input logic wv);
        w = wv;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (wv) run[i] = (run[i] + 1 > len[i]) ? len[i] : run[i] + 1;
            else    run[i] = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) run[i] = 0;
        for (int c = 0; c < 5; c++) begin
            w = c[0];
            @(posedge clk);
            #1;
            n_checks++;
            if (zv !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_z cycle %0d: got %b want 000", c, zv);
            end
            n_checks++;
            if (u_len2.state !== S0) begin
                n_fail++;
                $display("FAIL reset_state cycle %0d: got %0d want 0", c, u_len2.state);
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [1:0] want2;
        want2 = 2'b10;
        for (int e = 0; e < 2; e++) begin
            clock_in(1'b1);
            n_checks++;
            if (z2 !== want2[e]) begin
                n_fail++;
                $display("FAIL basic_z2 edge %0d: got %b want %b", e + 1, z2, want2[e]);
            end
        end
    endtask

    task automatic test_held();
        clock_in(1'b0);
        for (int e = 1; e <= 10; e++) begin
            clock_in(1'b1);
            n_checks++;
            if (z2 !== (e >= 2)) begin
                n_fail++;
                $display("FAIL held_z2 edge %0d: got %b want %b", e, z2, (e >= 2));
            end
        end
        clock_in(1'b0);
        n_checks++;
        if (zv !== 3'b000) begin
            n_fail++;
            $display("FAIL held_release: got %b want 000", zv);
        end
    endtask

    task automatic test_broken();
        logic [4:0] seq;
        seq = 5'b10101;
        clock_in(1'b0);
        for (int e = 0; e < 5; e++) begin
            clock_in(seq[e]);
            n_checks++;
            if ({z3, z2} !== 2'b00) begin
                n_fail++;
                $display("FAIL broken_z3z2 edge %0d: got %b want 00", e + 1, {z3, z2});
            end
            n_checks++;
            if (z1 !== seq[e]) begin
                n_fail++;
                $display("FAIL broken_z1 edge %0d: got %b want %b", e + 1, z1, seq[e]);
            end
        end
    endtask

    task automatic test_async_reset();
        clock_in(1'b1);
        clock_in(1'b1);
        n_checks++;
        if (z2 !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre z2: got %b want 1", z2);
        end
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) run[i] = 0;
        n_checks++;
        if (zv !== 3'b000) begin
            n_fail++;
            $display("FAIL async_assert: got %b want 000", zv);
        end
        @(negedge clk);
        reset = 1'b1;
        clock_in(1'b1);
        n_checks++;
        if (z2 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_after1 z2: got %b want 0", z2);
        end
        clock_in(1'b1);
        n_checks++;
        if (z2 !== 1'b1) begin
            n_fail++;
            $display("FAIL async_after2 z2: got %b want 1", z2);
        end
    endtask

    task automatic test_run_len();
        logic [2:0] want3;
        want3 = 3'b100;
        clock_in(1'b0);
        for (int e = 0; e < 3; e++) begin
            clock_in(1'b1);
            n_checks++;
            if (z3 !== want3[e]) begin
                n_fail++;
                $display("FAIL len3_z3 edge %0d: got %b want %b", e + 1, z3, want3[e]);
            end
            n_checks++;
            if (z1 !== 1'b1) begin
                n_fail++;
                $display("FAIL len1_z1 edge %0d: got %b want 1", e + 1, z1);
            end
        end
    endtask

    task automatic test_random();
        logic wv;
        for (int c = 0; c < 400; c++) begin
            wv = ($urandom_range(0, 3) != 0);
            clock_in(wv);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (zv[i] !== (run[i] == len[i])) begin
                    n_fail++;
                    $display("FAIL random_len%0d cycle %0d: got %b want %b",
                             len[i], c, zv[i], (run[i] == len[i]));
                end
            end
            n_checks++;
            if (z1 !== wv) begin
                n_fail++;
                $display("FAIL random_delay cycle %0d: got %b want %b", c, z1, wv);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        len[0] = 1;
        len[1] = 2;
        len[2] = 3;
        w      = 1'b0;
        reset  = 1'b0;
        #1;
        n_checks++;
        if (zv !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_initial: got %b want 000", zv);
        end
        test_reset();
        test_basic();
        test_held();
        test_broken();
        test_async_reset();
        test_run_len();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/secuencia_moore.md
SECUENCIA_MOORE -- requirements
Module: secuencia_moore

Interface
REQ-001 The block SHALL have parameter RUN_LEN, default 2, meaning the number of consecutive w=1 samples needed to assert z; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port w, input, 1 bit, the serial input sampled on each rising clk edge.
REQ-005 The block SHALL have port z, output, 1 bit, the detection flag, a Moore output that depends on state only.

Function
REQ-006 The block SHALL implement a Moore FSM with RUN_LEN+1 states S0..S_RUN_LEN; state Sk means the last k sampled w values were 1, saturating at S_RUN_LEN.
REQ-007 On a rising clk edge with w=0, the next state SHALL be S0 from any state.
REQ-008 On a rising clk edge with w=1, the next state SHALL be S(k+1) from Sk for k<RUN_LEN, and SHALL stay S_RUN_LEN from S_RUN_LEN.
REQ-009 z SHALL be 1 only in state S_RUN_LEN, and SHALL be 0 in every other state.
REQ-010 z SHALL be decoded from the registered state only and SHALL have no combinational path from w.
REQ-011 Latency: z SHALL rise in the cycle after the RUN_LEN-th consecutive rising edge that samples w=1.
REQ-012 z SHALL fall in the cycle after the first rising edge that samples w=0.
REQ-013 Overlapping runs SHALL be handled: with w held at 1, z SHALL stay 1 indefinitely.
REQ-014 For RUN_LEN=1, z SHALL be w delayed by one clock.
REQ-015 Any state encoding that is not a legal state SHALL go to S0 on the next rising clk edge.

Reset
REQ-016 While reset=0, the state SHALL be forced to S0 and z SHALL be 0 immediately, without waiting for a clk edge.
REQ-017 Reset asserted mid-run SHALL discard the run; counting SHALL restart from S0 after release.
REQ-018 The first rising edge after reset goes to 1 SHALL sample w normally.

Structure
REQ-019 The state type, state constants and RUN_LEN default SHALL live in a shared package, secuencia_pkg.
REQ-020 The block SHALL be one module with three sections: state register, next-state logic and output decode.
REQ-021 No sub-module SHALL be used; a separate next-state module would add no reuse.

Verification
REQ-022 Bench, reset asserted: reset=0 with w toggling over 5 clocks -> z=0 throughout, state S0.
REQ-023 Bench, basic detect: reset released, w=1,1 on two edges -> z=0 after edge 1, z=1 after edge 2.
REQ-024 Bench, held input: w held at 1 for 10 edges -> z=1 from edge 2 through edge 10; then w=0 -> z=0 after the next edge.
REQ-025 Bench, broken run: w sequence 1,0,1,0,1 -> z=0 on every cycle.
REQ-026 Bench, asynchronous reset: reset pulled to 0 between clk edges while z=1 -> z=0 before the next edge; after release, w=1,1 -> z=1 again after two edges.
REQ-027 Bench, parameter: RUN_LEN=3 with w=1,1,1 -> z=1 only after edge 3; also check RUN_LEN=1 gives z equal to w delayed one cycle.
